// File: rtl/lfsr_mem_pkg.sv
// Shared definitions for the LFSR associative memory path (writer and search side).
// Both ends import this package so they walk the identical address sequence.
package lfsr_mem_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 16;

  // Fibonacci taps for x^16+x^14+x^13+x^11+1 (bits 15,13,12,10)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] SEED_DEF  = 16'hACE1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_CHECK,
    ST_DONE
  } wr_state_e;

endpackage

// File: rtl/lfsr16_step.sv
// One step of the left-shifting Fibonacci LFSR; feedback (XOR of tapped bits)
// enters bit 0. Purely combinational so the search side can reuse it.
module lfsr16_step #(
  parameter int unsigned    W    = 16,
  parameter logic [W-1:0]   TAPS = 16'hB400
) (
  input  logic [W-1:0] lfsr_i,
  output logic [W-1:0] lfsr_o
);

  assign lfsr_o = {lfsr_i[W-2:0], ^(lfsr_i & TAPS)};

endmodule

// File: rtl/lfsr_assoc_writer.sv
// Store-side writer: assigns each accepted byte the next LFSR address, writes it
// to the shared memory and reports the address used.
// Optional read-back verification is enabled by defining LFSR_WRITER_VERIFY_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for WR_Req; Clear restarts the sequence here only
// ST_WRITE | Mem_WR high at the current LFSR address
// ST_READ  | (verify) Mem_RD high at the same address
// ST_CHECK | (verify) compare read-back with the latched byte
// ST_DONE  | Done pulse; Address_out, LFSR and count already advanced
module lfsr_assoc_writer
  import lfsr_mem_pkg::*;
#(
  parameter int unsigned        DATA_W = DATA_W_DEF,
  parameter int unsigned        ADDR_W = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0]  SEED   = ADDR_W'(SEED_DEF)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Clear,
  input  logic [DATA_W-1:0] Data_in,
  input  logic              WR_Req,
  output logic              WR_Ack,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W-1:0] Address_out,
  output logic              Full,
  output logic              Overflow,
`ifdef LFSR_WRITER_VERIFY_EN
  output logic              Verify_Err,
`endif
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_Data_out,
  output logic              Mem_WR,
  output logic              Mem_RD,
  input  logic [DATA_W-1:0] Mem_Data_in
);

  wr_state_e         state_q, state_d;
  logic [ADDR_W-1:0] lfsr_q, lfsr_d;
  logic [ADDR_W-1:0] lfsr_nxt;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
`ifdef LFSR_WRITER_VERIFY_EN
  logic              err_q, err_d;
`else
  logic              unused_rd_data;
  assign unused_rd_data = ^Mem_Data_in;
`endif

  lfsr16_step #(
    .W    (ADDR_W),
    .TAPS (ADDR_W'(LFSR_TAPS))
  ) u_step (
    .lfsr_i (lfsr_q),
    .lfsr_o (lfsr_nxt)
  );

  // Next-state and strobes; the store is committed on the edge into ST_DONE so
  // Address_out and Full are already valid while Done is high.
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    count_d  = count_q;
    addr_d   = addr_q;
    data_d   = data_q;
    WR_Ack   = 1'b0;
    Overflow = 1'b0;
    Mem_WR   = 1'b0;
    Mem_RD   = 1'b0;
    Done     = 1'b0;
`ifdef LFSR_WRITER_VERIFY_EN
    err_d    = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (Clear) begin
          lfsr_d  = SEED;
          count_d = '0;
`ifdef LFSR_WRITER_VERIFY_EN
          err_d   = 1'b0;
`endif
        end else if (WR_Req) begin
          if (Full) begin
            Overflow = 1'b1;
          end else begin
            WR_Ack  = 1'b1;
            data_d  = Data_in;
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        Mem_WR = 1'b1;
`ifdef LFSR_WRITER_VERIFY_EN
        state_d = ST_READ;
`else
        addr_d  = lfsr_q;
        lfsr_d  = lfsr_nxt;
        count_d = count_q + ADDR_W'(1);
        state_d = ST_DONE;
`endif
      end
`ifdef LFSR_WRITER_VERIFY_EN
      ST_READ: begin
        Mem_RD  = 1'b1;
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (Mem_Data_in != data_q) begin
          err_d = 1'b1;
        end
        addr_d  = lfsr_q;
        lfsr_d  = lfsr_nxt;
        count_d = count_q + ADDR_W'(1);
        state_d = ST_DONE;
      end
`endif
      ST_DONE: begin
        Done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      lfsr_q  <= SEED;
      count_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef LFSR_WRITER_VERIFY_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
`ifdef LFSR_WRITER_VERIFY_EN
      err_q   <= err_d;
`endif
    end
  end

  assign Busy         = (state_q != ST_IDLE);
  assign Full         = (count_q == {ADDR_W{1'b1}});
  assign Address_out  = addr_q;
  assign Mem_Addr     = lfsr_q;
  assign Mem_Data_out = data_q;
`ifdef LFSR_WRITER_VERIFY_EN
  assign Verify_Err   = err_q;
`endif

endmodule

// File: tb/tb_lfsr_assoc_writer.sv
// Bench for lfsr_assoc_writer: cycle-level behavioural model plus directed pins.
module tb_lfsr_assoc_writer;
  import lfsr_mem_pkg::*;

`ifdef LFSR_WRITER_VERIFY_EN
  localparam int LAT = 4;
  localparam bit VER = 1'b1;
`else
  localparam int LAT = 2;
  localparam bit VER = 1'b0;
`endif
  localparam logic [15:0] SEED = 16'hACE1;

  logic        Clock, Reset, Clear, WR_Req;
  logic [7:0]  Data_in;
  logic        WR_Ack, Busy, Done, Full, Overflow, Mem_WR, Mem_RD;
  logic [15:0] Address_out, Mem_Addr;
  logic [7:0]  Mem_Data_out, Mem_Data_in;
  logic        err_o;
`ifdef LFSR_WRITER_VERIFY_EN
  logic        Verify_Err;
  assign err_o = Verify_Err;
`else
  assign err_o = 1'b0;
`endif

  lfsr_assoc_writer dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .Clear        (Clear),
    .Data_in      (Data_in),
    .WR_Req       (WR_Req),
    .WR_Ack       (WR_Ack),
    .Busy         (Busy),
    .Done         (Done),
    .Address_out  (Address_out),
    .Full         (Full),
    .Overflow     (Overflow),
`ifdef LFSR_WRITER_VERIFY_EN
    .Verify_Err   (Verify_Err),
`endif
    .Mem_Addr     (Mem_Addr),
    .Mem_Data_out (Mem_Data_out),
    .Mem_WR       (Mem_WR),
    .Mem_RD       (Mem_RD),
    .Mem_Data_in  (Mem_Data_in)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // 64K memory; read-back of a stored A5 is corrupted to 00
  logic [7:0] mem [0:65535];
  initial Mem_Data_in = 8'h00;
  always @(posedge Clock) begin
    if (Mem_WR) mem[Mem_Addr] <= Mem_Data_out;
    if (Mem_RD) Mem_Data_in <= (mem[Mem_Addr] == 8'hA5) ? 8'h00 : mem[Mem_Addr];
  end

  int vectors = 0;
  int miscompares = 0;

  // model state
  logic [15:0] m_lfsr;
  int          m_count;
  logic [15:0] m_addr;
  int          m_age;     // cycles since acceptance, 0 = idle
  logic [7:0]  m_data;
  bit          m_err;
  logic [7:0]  m_mem [int];

  function automatic logic [15:0] f_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lfsr = SEED; m_count = 0; m_addr = 16'h0; m_age = 0; m_data = 8'h00; m_err = 1'b0;
  endtask

  // compare DUT against model for the current cycle, then advance the model
  task automatic check_and_step();
    bit idle, full, e_ack, e_ovf;
    idle  = (m_age == 0);
    full  = (m_count == 65535);
    e_ack = idle && WR_Req && !full && !Clear;
    e_ovf = idle && WR_Req && full && !Clear;
    chk("wr_ack", WR_Ack, e_ack);
    chk("overflow", Overflow, e_ovf);
    chk("busy", Busy, !idle);
    chk("done", Done, m_age == LAT);
    chk("full", Full, full);
    chk("mem_wr", Mem_WR, m_age == 1);
    chk("mem_rd", Mem_RD, VER && m_age == 2);
    chk("mem_addr", Mem_Addr, m_lfsr);
    chk("address_out", Address_out, m_addr);
    chk("verify_err", err_o, m_err);
    if (m_age == 1) chk("mem_data_out", Mem_Data_out, m_data);
    if (e_ack) begin
      m_data = Data_in;
      m_age  = 1;
    end else if (idle && Clear) begin
      m_lfsr = SEED; m_count = 0; m_err = 1'b0;
    end else if (!idle) begin
      if (m_age == 1) m_mem[m_lfsr] = m_data;
      if (m_age == LAT) m_age = 0;
      else begin
        m_age++;
        if (m_age == LAT) begin
          m_addr  = m_lfsr;
          m_lfsr  = f_step(m_lfsr);
          m_count = m_count + 1;
          if (VER && m_data == 8'hA5) m_err = 1'b1;
        end
      end
    end
  endtask

  task automatic cycle(input bit req, input logic [7:0] d, input bit clr);
    @(negedge Clock);
    WR_Req = req; Data_in = d; Clear = clr;
    #1;
    check_and_step();
  endtask

  logic [15:0] got [3];
  logic [7:0]  b2b  [3];
  int k, n, lat;
  logic [15:0] v;

  initial begin
    Reset = 1'b1; Clear = 1'b0; WR_Req = 1'b0; Data_in = 8'h00;
    model_reset();
    #1;
    chk("rst_busy", Busy, 0);
    chk("rst_addr_out", Address_out, 0);
    chk("rst_mem_addr", Mem_Addr, 16'hACE1);
    chk("rst_mem_data", Mem_Data_out, 0);
    chk("rst_strobes", {WR_Ack, Done, Full, Overflow, Mem_WR, Mem_RD}, 6'b0);

    // model pins: first steps and full period
    chk("pin_step1", f_step(SEED), 16'h59C3);
    chk("pin_step2", f_step(16'h59C3), 16'hB387);
    v = f_step(SEED); n = 1;
    while (v != SEED && n < 70000) begin v = f_step(v); n++; end
    chk("pin_period", n, 65535);

    @(negedge Clock); Reset = 1'b0;

    // first store
    cycle(1, 8'h3C, 0);
    chk("t1_ack", WR_Ack, 1);
    cycle(0, 8'h00, 0);
    chk("t1_wr", Mem_WR, 1);
    chk("t1_wr_addr", Mem_Addr, 16'hACE1);
    repeat (LAT - 1) cycle(0, 8'h00, 0);
    chk("t1_done", Done, 1);
    chk("t1_addr", Address_out, 16'hACE1);

    // restart, then three back-to-back stores
    cycle(0, 8'h00, 1);
    b2b[0] = 8'h11; b2b[1] = 8'h22; b2b[2] = 8'h33;
    k = 0; n = 0;
    for (int i = 0; i < 3 * (LAT + 1) + 2; i++) begin
      cycle(k < 3, (k < 3) ? b2b[k] : 8'h00, 0);
      if (WR_Ack) k++;
      if (Done && n < 3) begin got[n] = Address_out; n++; end
    end
    chk("b2b_count", n, 3);
    chk("b2b_a0", got[0], 16'hACE1);
    chk("b2b_a1", got[1], 16'h59C3);
    chk("b2b_a2", got[2], 16'hB387);
    chk("b2b_m0", mem[16'hACE1], 8'h11);
    chk("b2b_m1", mem[16'h59C3], 8'h22);
    chk("b2b_m2", mem[16'hB387], 8'h33);

    // five stores, Clear, next store returns to SEED
    k = 0;
    for (int i = 0; i < 40 && k < 5; i++) begin
      cycle(1, 8'($urandom), 0);
      if (WR_Ack) k++;
    end
    chk("clr_stores", k, 5);
    repeat (LAT) cycle(0, 8'h00, 0);
    cycle(1, 8'h77, 1);
    chk("clr_prio_ack", WR_Ack, 0);
    cycle(1, 8'h5A, 0);
    chk("clr_ack", WR_Ack, 1);
    repeat (LAT) cycle(0, 8'h00, 0);
    chk("clr_addr", Address_out, 16'hACE1);
    chk("clr_full", Full, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 24) == 0);
    repeat (LAT + 1) cycle(0, 8'h00, 0);

    // reset during WRITE
    cycle(1, 8'hC3, 0);
    @(negedge Clock);
    WR_Req = 1'b0; #1;
    chk("rstw_in_write", Mem_WR, 1);
    Reset = 1'b1; #1;
    chk("rstw_busy", Busy, 0);
    chk("rstw_strobes", {WR_Ack, Done, Full, Overflow, Mem_WR, Mem_RD, err_o}, 7'b0);
    chk("rstw_mem_addr", Mem_Addr, 16'hACE1);
    chk("rstw_addr_out", Address_out, 0);
    chk("rstw_mem_data", Mem_Data_out, 0);
    model_reset();
    @(negedge Clock); Reset = 1'b0;
    repeat (LAT + 1) cycle(0, 8'h00, 0);

    // full / overflow
    @(negedge Clock);
    force dut.count_q = 16'hFFFE;
    m_count = 65534;
    cycle(0, 8'h00, 0);
    release dut.count_q;
    cycle(1, 8'h9E, 0);
    chk("full_ack", WR_Ack, 1);
    repeat (LAT) cycle(0, 8'h00, 0);
    chk("full_done", Done, 1);
    chk("full_flag", Full, 1);
    cycle(1, 8'h44, 0);
    chk("ovf_pulse", Overflow, 1);
    chk("ovf_ack", WR_Ack, 0);
    cycle(0, 8'h00, 0);
    chk("ovf_no_wr", Mem_WR, 0);
    chk("ovf_pulse_end", Overflow, 0);
    cycle(0, 8'h00, 1);
    cycle(0, 8'h00, 0);
    chk("full_cleared", Full, 0);

`ifdef LFSR_WRITER_VERIFY_EN
    // corrupted read-back sets the sticky error
    cycle(1, 8'hA5, 0);
    lat = 0;
    while (!Done && lat < 10) begin cycle(0, 8'h00, 0); lat++; end
    chk("ver_latency", lat, 4);
    chk("ver_err", Verify_Err, 1);
    repeat (3) cycle(0, 8'h00, 0);
    chk("ver_err_sticky", Verify_Err, 1);
    cycle(0, 8'h00, 1);
    cycle(0, 8'h00, 0);
    chk("ver_err_clear", Verify_Err, 0);
`endif

    // memory contents against the model's record of completed writes
    foreach (m_mem[a]) chk("mem_content", mem[a], m_mem[a]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
